// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
// FSM encoding lives here so the top and the bench agree on it.
package dmem_arbiter_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way pick for the data-memory arbiter; round-robin on last_gnt.
// DMEM_ARB_FIXED_PRIO_EN: ties always go to requester 0.
import dmem_arbiter_pkg::*;

module dmem_arb_rr (
  input  logic clock,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic hint_vld,
  input  logic hint,
  input  logic gnt0,
  input  logic gnt1,
  output logic pick0,
  output logic pick1
);

`ifdef DMEM_ARB_FIXED_PRIO_EN

  logic unused_rr;

  assign unused_rr = ^{clock, reset, hint_vld,
                       hint, gnt0, gnt1};

  assign pick0 = req0;
  assign pick1 = req1 & ~req0;

`else

  logic last_gnt;
  logic last;

  // An owner leaving its burst counts as most recently served.
  assign last = hint_vld ? hint : last_gnt;

  assign pick0 = req0 & (~req1 | last);
  assign pick1 = req1 & (~req0 | ~last);

  always_ff @(posedge clock) begin
    if (reset) begin
      last_gnt <= 1'b1;
    end else if (gnt0) begin
      last_gnt <= 1'b0;
    end else if (gnt1) begin
      last_gnt <= 1'b1;
    end
  end

`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory with lock bursts.
// DMEM_ARB_FIXED_PRIO_EN selects fixed priority for idle ties.
import dmem_arbiter_pkg::*;

module dmem_arbiter #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_lock,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_lock,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic [ADDR_W-1:0] address_dmem,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q_dmem
);

  localparam int CW = $clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] BURST_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] ONE = CW'(1);

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_nxt;
  logic            arb;
  logic            own_exit;
  logic            own_last;
  logic            pick0;
  logic            pick1;
  logic            gnt0;
  logic            gnt1;
  logic            rv0_q;
  logic            rv1_q;

  dmem_arb_rr u_rr (
    .clock    (clock),
    .reset    (reset),
    .req0     (r0_req),
    .req1     (r1_req),
    .hint_vld (own_exit),
    .hint     (own_last),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .pick0    (pick0),
    .pick1    (pick1)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    arb       = 1'b0;
    own_exit  = 1'b0;
    own_last  = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    unique case (state)
      OWN0: begin
        if (r0_req && r0_lock && cnt < BURST_MAX) begin
          gnt0    = 1'b1;
          cnt_nxt = cnt + ONE;
        end else begin
          arb      = 1'b1;
          own_exit = 1'b1;
          own_last = 1'b0;
        end
      end
      OWN1: begin
        if (r1_req && r1_lock && cnt < BURST_MAX) begin
          gnt1    = 1'b1;
          cnt_nxt = cnt + ONE;
        end else begin
          arb      = 1'b1;
          own_exit = 1'b1;
          own_last = 1'b1;
        end
      end
      default: arb = 1'b1;
    endcase
    // Idle arbitration also covers the exit cycle of a burst.
    if (arb) begin
      gnt0      = pick0;
      gnt1      = pick1;
      state_nxt = IDLE;
      cnt_nxt   = '0;
      if (pick0 && r0_lock) begin
        state_nxt = OWN0;
        cnt_nxt   = ONE;
      end else if (pick1 && r1_lock) begin
        state_nxt = OWN1;
        cnt_nxt   = ONE;
      end
    end
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  always_comb begin
    address_dmem = '0;
    data         = '0;
    wren         = 1'b0;
    if (gnt0) begin
      address_dmem = r0_addr;
      data         = r0_wdata;
      wren         = r0_we;
    end else if (gnt1) begin
      address_dmem = r1_addr;
      data         = r1_wdata;
      wren         = r1_we;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rv0_q <= 1'b0;
      rv1_q <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rv0_q <= gnt0 & ~r0_we;
      rv1_q <= gnt1 & ~r1_we;
    end
  end

  // A read in flight when reset arrives never surfaces.
  assign r0_rvalid = rv0_q & ~reset;
  assign r1_rvalid = rv1_q & ~reset;
  assign r0_rdata  = q_dmem;
  assign r1_rdata  = q_dmem;
  assign r0_gnt    = gnt0;
  assign r1_gnt    = gnt1;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 12, memory address width; DATA_W, default 32, data width; MAX_BURST, default 8, maximum consecutive locked grants.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 rN_req  in  1  access request from requester N (N = 0 processor, N = 1 loader/debug).
REQ-005 rN_we  in  1  write when 1, read when 0; valid with rN_req.
REQ-006 rN_lock  in  1  request to keep ownership after this access.
REQ-007 rN_addr  in  ADDR_W  access address.
REQ-008 rN_wdata  in  DATA_W  write data.
REQ-009 rN_gnt  out  1  combinational; access accepted this cycle.
REQ-010 rN_rvalid  out  1  registered; read data valid on rN_rdata.
REQ-011 rN_rdata  out  DATA_W  read data, copy of q_dmem.
REQ-012 address_dmem  out  ADDR_W; data  out  DATA_W; wren  out  1; q_dmem  in  DATA_W  single-port data memory, read data one cycle after address.

Function
REQ-013 At most one of r0_gnt, r1_gnt SHALL be 1 per cycle; a grant requires the matching rN_req.
REQ-014 FSM states IDLE, OWN0, OWN1; registered state, combinational grant.
REQ-015 IDLE: one requester only -> granted; both -> requester not granted last (last_gnt register) wins.
REQ-016 Grant with rN_lock=1 -> next state OWNN, burst counter loaded with 1; otherwise -> IDLE.
REQ-017 OWNN: requester N has absolute priority; other requester receives no grant while N keeps req=1.
REQ-018 OWNN exits to IDLE when N deasserts req or lock, or counter reaches MAX_BURST; in the exit cycle, IDLE arbitration applies combinationally, with N treated as last granted.
REQ-019 OWNN with N req=0: the other requester SHALL be granted that cycle if requesting.
REQ-020 Burst counter increments per granted access in OWNN; width clog2(MAX_BURST)+1; no wrap.
REQ-021 Memory port SHALL present the granted requester's addr/wdata; wren = grant & rN_we; with no grant address_dmem = 0, data = 0, wren = 0.
REQ-022 Granted read -> rN_rvalid = 1 exactly one cycle later, rN_rdata = q_dmem; writes never raise rvalid.
REQ-023 Back-to-back reads to alternating requesters SHALL each return rvalid to the correct owner (1-deep owner pipeline register).
REQ-024 rN_rdata SHALL equal q_dmem whenever rN_rvalid = 1; value otherwise don't-care.
REQ-025 last_gnt updates on every grant.

Reset
REQ-026 Reset: state IDLE, last_gnt = 1 (requester 0 wins first tie), counter 0, both rvalid 0.
REQ-027 Reset mid-burst or mid-read SHALL drop ownership and the pending rvalid; no response is delivered after reset.
REQ-028 During reset cycles all gnt and wren SHALL be 0.

Configuration
REQ-029 Macro DMEM_ARB_FIXED_PRIO_EN: defined -> IDLE ties always go to requester 0, last_gnt unused; undefined -> round-robin per REQ-015.
REQ-030 Locking and burst limit SHALL behave identically in both builds.

Structure
REQ-031 Shared package holds FSM state encoding (IDLE/OWN0/OWN1) and default ADDR_W/DATA_W constants.
REQ-032 One sub-module, dmem_arb_rr, holds the two-way round-robin pick and last_gnt register; the FSM, counter and response pipeline stay in dmem_arbiter.

Verification
REQ-033 r0 read 0x010 alone, mem[0x010]=0xDEADBEEF -> r0_gnt same cycle, r0_rvalid next cycle with 0xDEADBEEF, r1_rvalid 0.
REQ-034 After reset, both req held, no lock, 4 cycles -> grants r0, r1, r0, r1; fixed-prio build -> r0 x4.
REQ-035 r0 lock=1 with continuous req, r1 req=1 throughout, MAX_BURST=8 -> r0 granted 8 consecutive cycles, then r1 granted.
REQ-036 r1 write 0x0AB data 0x12345678, then r0 read 0x0AB next cycle -> wren=1 once, r0_rdata = 0x12345678, no r1_rvalid.
REQ-037 Alternating r0 read 0x001, r1 read 0x002 each cycle -> rvalid routed to issuing requester with matching data, never both high.
REQ-038 Reset asserted in cycle after granted r1 read during OWN1 -> r1_rvalid stays 0, state IDLE, next tie goes to r0.
